bsg_fpu_preprocess_normalize: RTL and testbench



---
 rtl/bsg_fpu_preprocess_normalize.sv | 114 +++++++++++
 tb/tb_bsg_fpu_preprocess_normalize.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_preprocess_normalize.sv
// Sequential FP operand classifier: registers class flags, sign, extended exponent and
// explicit-hidden-bit mantissa, optionally normalising denormals one bit per cycle.
module bsg_fpu_preprocess_normalize #(
    parameter int e_p         = 8,
    parameter int m_p         = 23,
    parameter int normalize_p = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             v_i,
    input  logic [e_p+m_p:0] a_i,
    output logic             ready_o,
    output logic             v_o,
    input  logic             yumi_i,
    output logic             zero_o,
    output logic             nan_o,
    output logic             sig_nan_o,
    output logic             infty_o,
    output logic             denormal_o,
    output logic             sign_o,
    output logic [e_p:0]     exp_o,
    output logic [m_p:0]     man_o
);

    localparam bit norm_en_lp = (normalize_p != 0);

    typedef enum logic [1:0] {eReady, eNorm, eDone} state_e;

    state_e         state_r, state_n;
    logic [e_p:0]   exp_r, exp_n;
    logic [m_p:0]   man_r, man_n;

    logic [e_p-1:0] a_exp;
    logic [m_p-1:0] a_man;
    logic           a_sign, exp_zero, exp_ones, man_zero, a_denorm, accept;

    assign a_sign   = a_i[e_p+m_p];
    assign a_exp    = a_i[e_p+m_p-1:m_p];
    assign a_man    = a_i[m_p-1:0];
    assign exp_zero = ~|a_exp;
    assign exp_ones = &a_exp;
    assign man_zero = ~|a_man;
    assign a_denorm = exp_zero & ~man_zero;

    // yumi_i feeds ready_o combinationally so a new operand can land as the old one leaves
    assign ready_o = (state_r == eReady) | ((state_r == eDone) & yumi_i);
    assign accept  = v_i & ready_o;
    assign v_o     = (state_r == eDone);
    assign exp_o   = exp_r;
    assign man_o   = man_r;

    always_comb begin
        state_n = state_r;
        exp_n   = exp_r;
        man_n   = man_r;
        case (state_r)
            eReady, eDone: begin
                if (accept) begin
                    if (a_denorm && norm_en_lp) begin
                        // exponent starts at 1 and drops once per shift, ending at -lz
                        man_n   = {1'b0, a_man};
                        exp_n   = {{e_p{1'b0}}, 1'b1};
                        state_n = eNorm;
                    end else begin
                        man_n   = {~exp_zero, a_man};
                        exp_n   = {1'b0, a_exp};
                        state_n = eDone;
                    end
                end else if (state_r == eDone && yumi_i) begin
                    state_n = eReady;
                end
            end
            eNorm: begin
                man_n = {man_r[m_p-1:0], 1'b0};
                exp_n = exp_r - {{e_p{1'b0}}, 1'b1};
                if (man_r[m_p-1]) begin
                    state_n = eDone;
                end
            end
            default: state_n = eReady;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eReady;
            exp_r   <= '0;
            man_r   <= '0;
        end else begin
            state_r <= state_n;
            exp_r   <= exp_n;
            man_r   <= man_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            zero_o     <= 1'b0;
            nan_o      <= 1'b0;
            sig_nan_o  <= 1'b0;
            infty_o    <= 1'b0;
            denormal_o <= 1'b0;
            sign_o     <= 1'b0;
        end else if (accept) begin
            zero_o     <= exp_zero & man_zero;
            nan_o      <= exp_ones & ~man_zero;
            sig_nan_o  <= exp_ones & ~man_zero & ~a_man[m_p-1];
            infty_o    <= exp_ones & man_zero;
            denormal_o <= a_denorm;
            sign_o     <= a_sign;
        end
    end

endmodule

// File: tb/tb_bsg_fpu_preprocess_normalize.sv
// Directed vector bench for bsg_fpu_preprocess_normalize (binary32 layout), with a
// second instance built without normalisation.
module tb_bsg_fpu_preprocess_normalize;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v_i = 1'b0, yumi = 1'b0;
    logic [31:0] a_i = '0;
    logic        ready_o, v_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o, sign_o;
    logic [8:0]  exp_o;
    logic [23:0] man_o;

    logic        v_i2 = 1'b0, yumi2 = 1'b0;
    logic        ready2, v2, zero2, nan2, sig2, inf2, den2, sign2;
    logic [8:0]  exp2;
    logic [23:0] man2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bsg_fpu_preprocess_normalize #(.e_p(8), .m_p(23), .normalize_p(1)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .a_i(a_i), .ready_o(ready_o), .v_o(v_o),
        .yumi_i(yumi), .zero_o(zero_o), .nan_o(nan_o), .sig_nan_o(sig_nan_o),
        .infty_o(infty_o), .denormal_o(denormal_o), .sign_o(sign_o),
        .exp_o(exp_o), .man_o(man_o)
    );

    bsg_fpu_preprocess_normalize #(.e_p(8), .m_p(23), .normalize_p(0)) dut_nn (
        .clk_i(clk), .reset_i(reset), .v_i(v_i2), .a_i(a_i), .ready_o(ready2), .v_o(v2),
        .yumi_i(yumi2), .zero_o(zero2), .nan_o(nan2), .sig_nan_o(sig2),
        .infty_o(inf2), .denormal_o(den2), .sign_o(sign2),
        .exp_o(exp2), .man_o(man2)
    );

    typedef struct {
        logic [31:0] a;
        int          lat;
        logic [8:0]  e;
        logic [23:0] m;
        logic [5:0]  f;   // {zero, nan, sig_nan, infty, denormal, sign}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(posedge clk) begin
        if (!reset && ((yumi && !v_o) || (yumi2 && !v2))) begin
            total++;
            $display("FAIL yumi_legal: yumi with v_o low at %0t", $time);
        end
    end

    // Present a on the normalising instance, wait for accept, return edges until v_o.
    task automatic run_op(input logic [31:0] a, output int lat);
        int n;
        @(negedge clk);
        a_i = a;
        v_i = 1'b1;
        n = 0;
        #1;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL ready_wait: ready_o=0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1 v_i = 1'b0;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (v_o) break;
        end
    endtask

    task automatic take;
        @(negedge clk);
        yumi = 1'b1;
        @(posedge clk);
        #1 yumi = 1'b0;
    endtask

    initial begin
        int lat;
        logic [8:0] e_seq[4];
        logic [31:0] a_seq[4];

        vecs[0] = '{32'h3F800000,  1, 9'h07F, 24'h800000, 6'b000000};
        vecs[1] = '{32'h00000001, 24, 9'h1EA, 24'h800000, 6'b000010};
        vecs[2] = '{32'h00400000,  2, 9'h000, 24'h800000, 6'b000010};
        vecs[3] = '{32'h7F800001,  1, 9'h0FF, 24'h800001, 6'b011000};
        vecs[4] = '{32'h7FC00000,  1, 9'h0FF, 24'hC00000, 6'b010000};
        vecs[5] = '{32'hFF800000,  1, 9'h0FF, 24'h800000, 6'b000101};
        vecs[6] = '{32'h80000000,  1, 9'h000, 24'h000000, 6'b100001};
        vecs[7] = '{32'h00000100, 16, 9'h1F2, 24'h800000, 6'b000010};
        vecs[8] = '{32'h007FFFFF,  2, 9'h000, 24'hFFFFFE, 6'b000010};
        vecs[9] = '{32'h40490FDB,  1, 9'h080, 24'hC90FDB, 6'b000000};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_v_o", {31'b0, v_o}, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_exp", {23'b0, exp_o}, 32'd0);
        check("rst_man", {8'b0, man_o}, 32'd0);
        check("rst_flags", {26'b0, zero_o, nan_o, sig_nan_o, infty_o, denormal_o, sign_o}, 32'd0);

        for (int k = 0; k < 10; k++) begin
            run_op(vecs[k].a, lat);
            check($sformatf("lat[%0d]", k), lat, vecs[k].lat);
            check($sformatf("exp[%0d]", k), {23'b0, exp_o}, {23'b0, vecs[k].e});
            check($sformatf("man[%0d]", k), {8'b0, man_o}, {8'b0, vecs[k].m});
            check($sformatf("flags[%0d]", k),
                  {26'b0, zero_o, nan_o, sig_nan_o, infty_o, denormal_o, sign_o},
                  {26'b0, vecs[k].f});
            check($sformatf("busy_ready[%0d]", k), {31'b0, ready_o}, 32'd0);
            take();
        end

        // Non-normalising instance passes the denormal through in one cycle.
        @(negedge clk);
        a_i = 32'h00400000;
        v_i2 = 1'b1;
        @(posedge clk);
        #1 v_i2 = 1'b0;
        @(negedge clk);
        check("nn_v_o", {31'b0, v2}, 32'd1);
        check("nn_exp", {23'b0, exp2}, 32'h000);
        check("nn_man", {8'b0, man2}, 32'h400000);
        check("nn_den", {31'b0, den2}, 32'd1);
        yumi2 = 1'b1;
        @(posedge clk);
        #1 yumi2 = 1'b0;

        // Back-to-back stream with yumi held high.
        a_seq[0] = 32'h3F800000; e_seq[0] = 9'h07F;
        a_seq[1] = 32'h40000000; e_seq[1] = 9'h080;
        a_seq[2] = 32'h40800000; e_seq[2] = 9'h081;
        a_seq[3] = 32'h41000000; e_seq[3] = 9'h082;
        @(negedge clk);
        a_i = a_seq[0];
        v_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("strm_v[%0d]", k), {31'b0, v_o}, 32'd1);
            check($sformatf("strm_exp[%0d]", k), {23'b0, exp_o}, {23'b0, e_seq[k-1]});
            a_i = a_seq[k];
            yumi = 1'b1;
            #1;
            check($sformatf("strm_ready[%0d]", k), {31'b0, ready_o}, 32'd1);
            @(posedge clk);
        end
        // Stall 5 cycles with a competing operand offered: it must be ignored.
        @(negedge clk);
        yumi = 1'b0;
        a_i = 32'h3F800000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_v", {31'b0, v_o}, 32'd1);
            check("stall_ready", {31'b0, ready_o}, 32'd0);
            check("stall_exp", {23'b0, exp_o}, 32'h082);
            @(negedge clk);
        end
        v_i = 1'b0;
        yumi = 1'b1;
        @(posedge clk);
        #1 yumi = 1'b0;

        // Reset in the middle of normalisation drops the operand.
        @(negedge clk);
        a_i = 32'h00000001;
        v_i = 1'b1;
        @(posedge clk);
        #1 v_i = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_norm_busy", {31'b0, v_o | ready_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_v_o", {31'b0, v_o}, 32'd0);
        check("mid_rst_ready", {31'b0, ready_o}, 32'd1);
        check("mid_rst_exp", {23'b0, exp_o}, 32'd0);
        run_op(32'h3F800000, lat);
        check("post_rst_lat", lat, 1);
        check("post_rst_exp", {23'b0, exp_o}, 32'h07F);
        check("post_rst_man", {8'b0, man_o}, 32'h800000);
        take();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
